// File: rtl/lcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lcd_pkg                                                                    |
// | PCF8574 backpack bit map, HD44780 commands and frame-writer state encoding |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package lcd_pkg;

  localparam int BIT_BL = 3;
  localparam int BIT_EN = 2;
  localparam int BIT_RW = 1;
  localparam int BIT_RS = 0;

  localparam logic [7:0] FUNC_4BIT_2L = 8'h28;
  localparam logic [7:0] DISP_ON      = 8'h0C;
  localparam logic [7:0] CLEAR        = 8'h01;
  localparam logic [7:0] ENTRY_INC    = 8'h06;
  localparam logic [7:0] DDRAM_L1     = 8'h80;
  localparam logic [7:0] DDRAM_L2     = 8'hC0;

  // Long settle time the HD44780 needs after the first 0x3 wake-up nibble
  localparam int unsigned INIT_WAIT0_US = 4100;

  typedef enum logic [3:0] {
    PWRUP    = 4'd0,
    INIT_NIB = 4'd1,
    INIT_CMD = 4'd2,
    LATCH    = 4'd3,
    ADDR1    = 4'd4,
    ROW1     = 4'd5,
    ADDR2    = 4'd6,
    ROW2     = 4'd7,
    DONE     = 4'd8
  } state_t;

  function automatic logic [7:0] pcf_byte(input logic [3:0] nib, input logic bl,
                                          input logic en, input logic rs);
    logic [7:0] b;
    b         = '0;
    b[7:4]    = nib;
    b[BIT_BL] = bl;
    b[BIT_EN] = en;
    b[BIT_RW] = 1'b0;
    b[BIT_RS] = rs;
    return b;
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return FUNC_4BIT_2L;
      2'd1:    return DISP_ON;
      2'd2:    return CLEAR;
      default: return ENTRY_INC;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcf8574_byte_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pcf8574_byte_framer                                                        |
// | Splits one LCD byte (or a lone nibble) into EN-strobed PCF8574 bytes       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pcf8574_byte_framer
  import lcd_pkg::*;
#(
  parameter bit BACKLIGHT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  input  logic       rs_i,
  input  logic       nib_only_i,
  input  logic       tx_ready_i,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  output logic       done_o
);

  logic [7:0] byte_q;
  logic [7:0] data_q;
  logic       rs_q;
  logic       nib_q;
  logic       valid_q;
  logic [1:0] cnt_q;
  logic [1:0] cnt_nxt;
  logic       xfer;
  logic       last;

  // Byte k: high nibble for k<2, EN high on even k
  function automatic logic [7:0] nib_frame(input logic [7:0] b, input logic [1:0] k,
                                           input logic rs);
    return pcf_byte(k[1] ? b[3:0] : b[7:4], BACKLIGHT, ~k[0], rs);
  endfunction

  assign xfer    = valid_q && tx_ready_i;
  assign last    = nib_q ? (cnt_q == 2'd1) : (cnt_q == 2'd3);
  assign cnt_nxt = cnt_q + 2'd1;
  assign done_o  = xfer && last;

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_q  <= '0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      nib_q   <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else if (start_i) begin
      byte_q  <= byte_i;
      rs_q    <= rs_i;
      nib_q   <= nib_only_i;
      cnt_q   <= '0;
      valid_q <= 1'b1;
      data_q  <= nib_frame(byte_i, 2'd0, rs_i);
    end else if (xfer) begin
      if (last) begin
        valid_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_nxt;
        data_q <= nib_frame(byte_q, cnt_nxt, rs_q);
      end
    end
  end

  assign tx_data_o  = data_q;
  assign tx_valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/lcd_frame_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lcd_frame_writer                                                           |
// | HD44780 4-bit init then continuous 2x16 refresh through a PCF8574 backpack |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module lcd_frame_writer
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned PWRUP_US  = 40000,
  parameter int unsigned CLR_US    = 2000,
  parameter int unsigned CMD_US    = 50,
  parameter bit          BACKLIGHT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] row1,
  input  logic [127:0] row2,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         init_done,
  output logic         frame_done
);

  localparam int unsigned CYC_US   = CLK_HZ / 1_000_000;
  localparam int unsigned MAX_A    = (PWRUP_US > INIT_WAIT0_US) ? PWRUP_US : INIT_WAIT0_US;
  localparam int unsigned MAX_B    = (CLR_US > CMD_US) ? CLR_US : CMD_US;
  localparam int unsigned MAX_US   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int          TW       = $clog2(MAX_US * CYC_US + 1);
  // Two cycles of start/valid pipeline are folded into the power-up count
  localparam int unsigned PWR_LAST = PWRUP_US * CYC_US - 2;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic          wait_q;
  logic          start_q;
  logic [3:0]    idx_q;
  logic          init_done_q;
  logic          frame_done_q;
  logic [127:0]  row1_q;
  logic [127:0]  row2_q;

  logic [7:0]    fr_byte;
  logic          fr_rs;
  logic          fr_nib;
  logic          fr_done;
  logic [3:0]    char_sel;
  int unsigned   wait_us;
  logic [TW-1:0] wait_load;

  assign char_sel = 4'd15 - idx_q;

  always_comb begin
    fr_byte = 8'h00;
    fr_rs   = 1'b0;
    fr_nib  = 1'b0;
    case (state_q)
      INIT_NIB: begin
        fr_byte = (idx_q == 4'd3) ? 8'h20 : 8'h30;
        fr_nib  = 1'b1;
      end
      INIT_CMD: fr_byte = init_cmd(idx_q[1:0]);
      ADDR1:    fr_byte = DDRAM_L1;
      ROW1: begin
        fr_byte = row1_q[{char_sel, 3'b000} +: 8];
        fr_rs   = 1'b1;
      end
      ADDR2:    fr_byte = DDRAM_L2;
      ROW2: begin
        fr_byte = row2_q[{char_sel, 3'b000} +: 8];
        fr_rs   = 1'b1;
      end
      default: ;
    endcase
  end

  // Timer loads W-1 so exactly W idle cycles separate the last byte and the next
  always_comb begin
    wait_us = CMD_US;
    if (state_q == INIT_NIB && idx_q == 4'd0) begin
      wait_us = INIT_WAIT0_US;
    end else if (state_q == INIT_CMD && fr_byte == CLEAR) begin
      wait_us = CLR_US;
    end
  end
  assign wait_load = TW'(wait_us * CYC_US - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= PWRUP;
      timer_q      <= '0;
      wait_q       <= 1'b0;
      start_q      <= 1'b0;
      idx_q        <= '0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      row1_q       <= '0;
      row2_q       <= '0;
    end else begin
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;
      if (fr_done) begin
        wait_q  <= 1'b1;
        timer_q <= wait_load;
      end else if (wait_q) begin
        if (timer_q < TW'(2)) begin
          wait_q  <= 1'b0;
          timer_q <= '0;
          idx_q   <= idx_q + 4'd1;
          start_q <= 1'b1;
          case (state_q)
            INIT_NIB: if (idx_q == 4'd3) begin
              state_q <= INIT_CMD;
              idx_q   <= '0;
            end
            INIT_CMD: if (idx_q == 4'd3) begin
              state_q     <= LATCH;
              idx_q       <= '0;
              start_q     <= 1'b0;
              init_done_q <= 1'b1;
            end
            ADDR1: begin
              state_q <= ROW1;
              idx_q   <= '0;
            end
            ROW1: if (idx_q == 4'd15) state_q <= ADDR2;
            ADDR2: begin
              state_q <= ROW2;
              idx_q   <= '0;
            end
            ROW2: if (idx_q == 4'd15) begin
              state_q      <= DONE;
              start_q      <= 1'b0;
              frame_done_q <= 1'b1;
            end
            default: ;
          endcase
        end else begin
          timer_q <= timer_q - TW'(1);
        end
      end else begin
        case (state_q)
          PWRUP: begin
            if (timer_q >= TW'(PWR_LAST)) begin
              state_q <= INIT_NIB;
              idx_q   <= '0;
              timer_q <= '0;
              start_q <= 1'b1;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          LATCH: begin
            row1_q  <= row1;
            row2_q  <= row2;
            state_q <= ADDR1;
            idx_q   <= '0;
            start_q <= 1'b1;
          end
          DONE:    state_q <= LATCH;
          default: ;
        endcase
      end
    end
  end

  pcf8574_byte_framer #(
    .BACKLIGHT (BACKLIGHT)
  ) u_framer (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_q),
    .byte_i     (fr_byte),
    .rs_i       (fr_rs),
    .nib_only_i (fr_nib),
    .tx_ready_i (tx_ready),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .done_o     (fr_done)
  );

  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lcd_frame_writer                                                        |
// | Directed self-checking bench for lcd_frame_writer                          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_lcd_frame_writer;

  localparam int TIMEOUT = 6000;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] row1;
  logic [127:0] row2;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         init_done;
  logic         frame_done;

  int n_cmp  = 0;
  int n_fail = 0;
  int fd_cnt = 0;
  int fd_exp = 0;
  bit stall_mode = 1'b0;

  logic [127:0] txt_a;
  logic [127:0] txt_sp;
  logic [127:0] txt_cotton;
  logic [127:0] txt_woody;
  logic [127:0] txt_buzz;

  logic [7:0] init_b [24] = '{8'h3C, 8'h38, 8'h3C, 8'h38, 8'h3C, 8'h38, 8'h2C, 8'h28,
                              8'h2C, 8'h28, 8'h8C, 8'h88, 8'h0C, 8'h08, 8'hCC, 8'hC8,
                              8'h0C, 8'h08, 8'h1C, 8'h18, 8'h0C, 8'h08, 8'h6C, 8'h68};
  int         init_g [24] = '{20, 0, 4100, 0, 2, 0, 2, 0,
                              2, 0, 0, 0, 2, 0, 0, 0,
                              2, 0, 0, 0, 10, 0, 0, 0};

  lcd_frame_writer #(
    .CLK_HZ    (1_000_000),
    .PWRUP_US  (20),
    .CLR_US    (10),
    .CMD_US    (2),
    .BACKLIGHT (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row1       (row1),
    .row2       (row2),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .init_done  (init_done),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pb(input logic [3:0] n, input logic en, input logic rs);
    return {n, 1'b1, en, 1'b0, rs};
  endfunction

  // Returns the next presented byte; gap = idle cycles seen before it
  task automatic next_byte(output logic [7:0] d, output int gap);
    int stall;
    gap = 0;
    @(negedge clk);
    if (frame_done) fd_cnt++;
    while (!tx_valid && gap < TIMEOUT) begin
      gap++;
      @(negedge clk);
      if (frame_done) fd_cnt++;
    end
    chk("valid_within_budget", {31'd0, tx_valid}, 32'd1);
    d = tx_data;
    if (stall_mode) begin
      stall = int'($urandom_range(7, 0));
      for (int s = 0; s < stall; s++) begin
        tx_ready = 1'b0;
        @(negedge clk);
        if (frame_done) fd_cnt++;
        chk("stall_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, d});
      end
      tx_ready = 1'b1;
    end
  endtask

  task automatic expect_lcd(input logic [7:0] b, input logic rs, input int g0, input string tag);
    logic [7:0] d;
    int         gap;
    logic [3:0] n;
    for (int k = 0; k < 4; k++) begin
      next_byte(d, gap);
      n = (k < 2) ? b[7:4] : b[3:0];
      chk(tag, {24'd0, d}, {24'd0, pb(n, (k % 2) == 0, rs)});
      if (k > 0) chk({tag, "_gap0"}, 32'(gap), 32'd0);
      else if (g0 >= 0) chk({tag, "_gap"}, 32'(gap), 32'(g0));
    end
  endtask

  task automatic run_frame(input logic [127:0] e1, input logic [127:0] e2,
                           input int chg_at, input logic [127:0] chg_val);
    expect_lcd(8'h80, 1'b0, -1, "addr1");
    chk("init_done_hi", {31'd0, init_done}, 32'd1);
    chk("frame_done_count", 32'(fd_cnt), 32'(fd_exp));
    for (int i = 0; i < 16; i++) begin
      if (i == chg_at) row1 = chg_val;
      expect_lcd(e1[8*(15-i) +: 8], 1'b1, 2, "row1_char");
    end
    expect_lcd(8'hC0, 1'b0, 2, "addr2");
    for (int i = 0; i < 16; i++) begin
      expect_lcd(e2[8*(15-i) +: 8], 1'b1, 2, "row2_char");
    end
    fd_exp++;
  endtask

  initial begin
    logic [7:0] d;
    int         gap;

    txt_a      = {"A", {15{8'h20}}};
    txt_sp     = {16{8'h20}};
    txt_cotton = {"Cotton", {10{8'h20}}};
    txt_woody  = {"Woody", {11{8'h20}}};
    txt_buzz   = {"Buzz", {12{8'h20}}};

    rst      = 1'b1;
    tx_ready = 1'b1;
    row1     = txt_a;
    row2     = txt_sp;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Power-up silence, wake-up nibbles and the four init commands
    for (int i = 0; i < 24; i++) begin
      next_byte(d, gap);
      chk("init_byte", {24'd0, d}, {24'd0, init_b[i]});
      chk("init_gap", 32'(gap), 32'(init_g[i]));
    end
    chk("init_done_during_wait", {31'd0, init_done}, 32'd0);

    run_frame(txt_a, txt_sp, -1, '0);

    stall_mode = 1'b1;
    run_frame(txt_a, txt_sp, -1, '0);
    stall_mode = 1'b0;

    // Snapshot: row1 changes mid-ROW1, the frame in flight keeps the old text
    row1 = txt_cotton;
    row2 = txt_buzz;
    run_frame(txt_cotton, txt_buzz, 3, txt_woody);
    run_frame(txt_woody, txt_buzz, -1, '0);

    // Reset while a ROW2 byte is presented
    expect_lcd(8'h80, 1'b0, -1, "addr1");
    for (int i = 0; i < 16; i++) expect_lcd(txt_woody[8*(15-i) +: 8], 1'b1, 2, "row1_char");
    expect_lcd(8'hC0, 1'b0, 2, "addr2");
    for (int i = 0; i < 3; i++) expect_lcd(txt_buzz[8*(15-i) +: 8], 1'b1, 2, "row2_char");
    next_byte(d, gap);
    chk("row2_before_rst", {24'd0, d}, {24'd0, pb(txt_buzz[103:100], 1'b1, 1'b1)});
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("midrst_init_done", {31'd0, init_done}, 32'd0);
    next_byte(d, gap);
    chk("restart_byte0", {24'd0, d}, 32'h3C);
    chk("restart_gap", 32'(gap), 32'd20);
    next_byte(d, gap);
    chk("restart_byte1", {24'd0, d}, 32'h38);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
